// File: rtl/fir_decim_round_if.sv
// Valid/ready stream carrying one signed output sample per beat.
// The master drives data/valid and the slave answers with ready.
interface fir_decim_round_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fir_decim_round.sv
// FIR output decimator: keep one sample per period, round (floor or half-to-even), narrow, FIFO.
// Define FIR_DECIM_SAT_EN to clamp on narrowing and report it on sat_o; otherwise narrowing wraps.
module fir_decim_round #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 15,
    parameter int DECIM_MAX  = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int DW = $clog2(DECIM_MAX + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IN_WIDTH-1:0] data_i,
    input  logic                valid_i,
    input  logic [DW-1:0]       decim_i,
    input  logic                round_mode_i,
    fir_decim_round_if.master   m,
    output logic                ovf_o,
    input  logic                clr_ovf_i,
    output logic                sat_o
);
    // Shifted stage-1 value width; OUT_WIDTH must not exceed it.
    localparam int S1W = IN_WIDTH + 1 - FRAC_SHIFT;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [IN_WIDTH:0] HALF_M1 =
        (IN_WIDTH+1)'((64'd1 << (FRAC_SHIFT - 1)) - 64'd1);

    // ---------------- decimation ----------------
    logic [DW-1:0] phase_reg;
    logic [DW-1:0] decim_eff_reg;
    logic [DW-1:0] decim_sel;
    logic          keep;

    always_comb begin
        decim_sel = (decim_i == '0) ? DW'(1) : decim_i;
        keep      = valid_i && (phase_reg == '0);
    end

    // The period length is only sampled at phase 0, so a running period is never cut short.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_reg     <= '0;
            decim_eff_reg <= DW'(1);
        end else if (valid_i) begin
            if (phase_reg == '0) begin
                decim_eff_reg <= decim_sel;
                phase_reg     <= (decim_sel == DW'(1)) ? '0 : DW'(1);
            end else if (phase_reg == decim_eff_reg - DW'(1)) begin
                phase_reg <= '0;
            end else begin
                phase_reg <= phase_reg + DW'(1);
            end
        end
    end

    // ---------------- stage 1: round and shift ----------------
    logic [IN_WIDTH:0]  rnd_add;
    logic [IN_WIDTH:0]  sum;
    logic               unused_frac;
    logic               s1_valid_reg;
    logic [S1W-1:0]     s1_data_reg;

    always_comb begin
        rnd_add = '0;
        if (round_mode_i) begin
            rnd_add = HALF_M1 + (IN_WIDTH+1)'(data_i[FRAC_SHIFT]);
        end
        sum = {data_i[IN_WIDTH-1], data_i} + rnd_add;
    end

    assign unused_frac = ^sum[FRAC_SHIFT-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= keep;
        end
        s1_data_reg <= sum[IN_WIDTH:FRAC_SHIFT];
    end

    // ---------------- stage 2: narrow ----------------
    logic [OUT_WIDTH-1:0] narrow;
    logic                 s2_valid_reg;
    logic [OUT_WIDTH-1:0] s2_data_reg;

`ifdef FIR_DECIM_SAT_EN
    localparam logic [OUT_WIDTH-1:0] MAX_VAL = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MIN_VAL = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    logic [S1W-OUT_WIDTH:0] top_bits;
    logic                   clamp;
    logic                   sat_reg;

    // In range exactly when every bit above the output sign bit repeats it.
    always_comb begin
        top_bits = s1_data_reg[S1W-1:OUT_WIDTH-1];
        clamp    = !((top_bits == '0) || (top_bits == '1));
        narrow   = s1_data_reg[OUT_WIDTH-1:0];
        if (clamp) begin
            narrow = s1_data_reg[S1W-1] ? MIN_VAL : MAX_VAL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sat_reg <= 1'b0;
        end else if (s1_valid_reg && clamp) begin
            sat_reg <= 1'b1;
        end else if (clr_ovf_i) begin
            sat_reg <= 1'b0;
        end
    end

    assign sat_o = sat_reg;
`else
    logic unused_hi;

    assign narrow    = s1_data_reg[OUT_WIDTH-1:0];
    assign unused_hi = ^s1_data_reg;
    assign sat_o     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid_reg <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
        end
        s2_data_reg <= narrow;
    end

    // ---------------- output FIFO ----------------
    logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [AW-1:0]        rd_ptr_next;
    logic [AW:0]          count_reg;
    logic [AW:0]          count_next;
    logic [AW:0]          held;
    logic                 pop;
    logic                 full;
    logic                 push;
    logic                 drop;
    logic                 m_valid_reg;
    logic [OUT_WIDTH-1:0] m_data_reg;
    logic                 ovf_reg;

    // held counts entries already stored before this edge's push, so a new entry shows up one cycle later.
    always_comb begin
        pop         = m_valid_reg && m.ready;
        full        = (count_reg == (AW+1)'(FIFO_DEPTH));
        push        = s2_valid_reg && (!full || pop);
        drop        = s2_valid_reg && full && !pop;
        held        = count_reg - (AW+1)'(pop);
        count_next  = held + (AW+1)'(push);
        rd_ptr_next = rd_ptr_reg + AW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= s2_data_reg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_reg + AW'(push);
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            m_valid_reg <= (held != '0);
            if (held != '0) begin
                m_data_reg <= mem[rd_ptr_next];
            end
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (clr_ovf_i) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign m.data  = m_data_reg;
    assign m.valid = m_valid_reg;
    assign ovf_o   = ovf_reg;

endmodule

// File: tb/tb_fir_decim_round.sv
// Self-checking bench for fir_decim_round: rounding/saturation vector table, hand-written
// decimation, back-pressure and reset sequences, and a randomized run against a reference model.
module tb_fir_decim_round;
    localparam int DW = $clog2(16 + 1);
`ifdef FIR_DECIM_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [31:0]   data_i;
    logic          valid_i;
    logic [DW-1:0] decim_i;
    logic          round_mode_i;
    logic          ovf_o;
    logic          clr_ovf_i;
    logic          sat_o;

    fir_decim_round_if #(.WIDTH(16)) m_if ();

    fir_decim_round dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .decim_i      (decim_i),
        .round_mode_i (round_mode_i),
        .m            (m_if),
        .ovf_o        (ovf_o),
        .clr_ovf_i    (clr_ovf_i),
        .sat_o        (sat_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] din;
        logic        mode;
        logic [15:0] exp;
        logic        exp_sat;
    } vec_t;

    vec_t        vecs [12];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];
    int          mdl_cnt = 0;
    int          mdl_period = 1;
    logic        mdl_sat = 1'b0;

    // One line per accepted output beat; the handshake completes at the next rising edge.
    always @(negedge clk_i) begin
        if (!rst_i && m_if.valid && m_if.ready) begin
            got_q.push_back(m_if.data);
            $display("xfer t=%0t data=%h", $time, m_if.data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_queues(input string name);
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), {16'h0, got_q[i]}, {16'h0, exp_q[i]});
        end
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        tick();
        tick();
        rst_i   = 1'b0;
        mdl_cnt = 0;
        mdl_sat = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [DW-1:0] dec,
                         input logic mode);
        valid_i      = v;
        data_i       = d;
        decim_i      = dec;
        round_mode_i = mode;
        tick();
    endtask

    // Reference: exact floor division by 2^15, then half-to-even correction, then clamp or wrap.
    function automatic logic [15:0] ref_out(input logic [31:0] d, input logic mode,
                                            output logic clamped);
        longint v;
        longint q;
        longint r;
        v = longint'($signed(d));
        q = v / 32768;
        if (v < 0 && (v % 32768) != 0) q = q - 1;
        r = v - q * 32768;
        if (mode && (r > 16384 || (r == 16384 && (q % 2) != 0))) q = q + 1;
        clamped = 1'b0;
        if (SAT_ON) begin
            if (q > 32767) begin
                q = 32767;
                clamped = 1'b1;
            end else if (q < -32768) begin
                q = -32768;
                clamped = 1'b1;
            end
        end
        return 16'(q);
    endfunction

    task automatic model_step(input logic v, input logic [31:0] d, input logic [DW-1:0] dec,
                              input logic mode);
        logic        c;
        logic [15:0] y;
        if (!v) return;
        if (mdl_cnt == 0) begin
            mdl_period = (dec == 0) ? 1 : int'(dec);
            y = ref_out(d, mode, c);
            exp_q.push_back(y);
            if (c) mdl_sat = 1'b1;
        end
        mdl_cnt = (mdl_cnt + 1) % mdl_period;
    endtask

    initial begin
        logic        prev_ready;
        logic        rdy;
        logic        v;
        logic        mode;
        logic [31:0] d;
        logic [DW-1:0] dec;

        vecs[0]  = '{32'h0000C000, 1'b1, 16'h0002, 1'b0};
        vecs[1]  = '{32'h0000C000, 1'b0, 16'h0001, 1'b0};
        vecs[2]  = '{32'h00014000, 1'b1, 16'h0002, 1'b0};
        vecs[3]  = '{32'hFFFF4000, 1'b1, 16'hFFFE, 1'b0};
        vecs[4]  = '{32'hFFFF4000, 1'b0, 16'hFFFE, 1'b0};
        vecs[5]  = '{32'h00004000, 1'b1, 16'h0000, 1'b0};
        vecs[6]  = '{32'h0000BFFF, 1'b1, 16'h0001, 1'b0};
        vecs[7]  = '{32'hFFFFC000, 1'b1, 16'h0000, 1'b0};
        vecs[8]  = '{32'h7FFFFFFF, 1'b0, SAT_ON ? 16'h7FFF : 16'hFFFF, SAT_ON};
        vecs[9]  = '{32'h80000000, 1'b0, SAT_ON ? 16'h8000 : 16'h0000, SAT_ON};
        vecs[10] = '{32'hFFFEC000, 1'b1, 16'hFFFE, 1'b0};
        vecs[11] = '{32'hFFFEC000, 1'b0, 16'hFFFD, 1'b0};

        rst_i        = 1'b1;
        valid_i      = 1'b0;
        data_i       = '0;
        decim_i      = DW'(1);
        round_mode_i = 1'b0;
        clr_ovf_i    = 1'b0;
        m_if.ready   = 1'b1;

        // Reset state
        do_reset();
        check("rst_valid", {31'h0, m_if.valid}, 32'h0);
        check("rst_data", {16'h0, m_if.data}, 32'h0);
        check("rst_ovf", {31'h0, ovf_o}, 32'h0);
        check("rst_sat", {31'h0, sat_o}, 32'h0);

        // Rounding / narrowing table, including three-cycle latency
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].din, DW'(1), vecs[i].mode);
            valid_i = 1'b0;
            tick();
            tick();
            check($sformatf("vec%0d_early", i), {31'h0, m_if.valid}, 32'h0);
            tick();
            check($sformatf("vec%0d_valid", i), {31'h0, m_if.valid}, 32'h1);
            check($sformatf("vec%0d_data", i), {16'h0, m_if.data}, {16'h0, vecs[i].exp});
            check($sformatf("vec%0d_sat", i), {31'h0, sat_o}, {31'h0, vecs[i].exp_sat});
            clr_ovf_i = 1'b1;
            tick();
            clr_ovf_i = 1'b0;
        end
        tick();
        tick();
        check("empty_valid", {31'h0, m_if.valid}, 32'h0);
        check("empty_hold", {16'h0, m_if.data}, {16'h0, vecs[11].exp});

        // Decimation by 4
        do_reset();
        for (int k = 0; k < 16; k++) drive(1'b1, 32'(k) << 15, DW'(4), 1'b0);
        valid_i = 1'b0;
        repeat (8) tick();
        exp_q = '{16'd0, 16'd4, 16'd8, 16'd12};
        compare_queues("decim4");

        // Change 4 -> 2 mid-period takes effect at the next kept sample
        do_reset();
        for (int k = 0; k < 16; k++) drive(1'b1, 32'(k) << 15, (k < 6) ? DW'(4) : DW'(2), 1'b0);
        valid_i = 1'b0;
        repeat (8) tick();
        exp_q = '{16'd0, 16'd4, 16'd8, 16'd10, 16'd12, 16'd14};
        compare_queues("decim_change");

        // decim 0 behaves as 1, one sample per clock
        do_reset();
        for (int k = 0; k < 5; k++) drive(1'b1, 32'(k) << 15, DW'(0), 1'b0);
        valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tput_valid%0d", i), {31'h0, m_if.valid}, 32'h1);
            tick();
        end
        check("tput_end", {31'h0, m_if.valid}, 32'h0);
        repeat (4) tick();
        exp_q = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4};
        compare_queues("decim0");

        // Back-pressure: four stored, fifth and sixth dropped
        do_reset();
        m_if.ready = 1'b0;
        for (int k = 0; k < 6; k++) drive(1'b1, 32'(k) << 15, DW'(1), 1'b0);
        valid_i = 1'b0;
        check("bp_ovf_before", {31'h0, ovf_o}, 32'h0);
        tick();
        check("bp_ovf_after5", {31'h0, ovf_o}, 32'h1);
        tick();
        tick();
        check("bp_valid", {31'h0, m_if.valid}, 32'h1);
        check("bp_head", {16'h0, m_if.data}, 32'h0);
        m_if.ready = 1'b1;
        repeat (8) tick();
        exp_q = '{16'd0, 16'd1, 16'd2, 16'd3};
        compare_queues("bp_drain");
        check("bp_empty", {31'h0, m_if.valid}, 32'h0);
        check("bp_ovf_sticky", {31'h0, ovf_o}, 32'h1);
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        check("bp_ovf_clr", {31'h0, ovf_o}, 32'h0);

        // Full FIFO with simultaneous pop and push
        do_reset();
        for (int k = 0; k < 12; k++) begin
            m_if.ready = (k >= 6);
            drive(1'b1, 32'(k) << 15, DW'(1), 1'b0);
        end
        valid_i    = 1'b0;
        m_if.ready = 1'b1;
        repeat (10) tick();
        exp_q = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5,
                  16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11};
        compare_queues("fullpop");
        check("fullpop_ovf", {31'h0, ovf_o}, 32'h0);

        // Reset with data in flight and in the FIFO, overflow flag set beforehand
        do_reset();
        m_if.ready = 1'b0;
        for (int k = 0; k < 5; k++) drive(1'b1, 32'(k) << 15, DW'(1), 1'b0);
        valid_i = 1'b0;
        tick();
        tick();
        check("rst_seq_ovf_pre", {31'h0, ovf_o}, 32'h1);
        m_if.ready = 1'b1;
        repeat (8) tick();
        got_q.delete();
        m_if.ready = 1'b0;
        for (int k = 10; k < 14; k++) drive(1'b1, 32'(k) << 15, DW'(1), 1'b0);
        check("rst_seq_pre_valid", {31'h0, m_if.valid}, 32'h1);
        data_i  = 32'(14) << 15;
        valid_i = 1'b1;
        rst_i   = 1'b1;
        tick();
        check("rst_seq_valid", {31'h0, m_if.valid}, 32'h0);
        check("rst_seq_ovf", {31'h0, ovf_o}, 32'h0);
        check("rst_seq_data", {16'h0, m_if.data}, 32'h0);
        rst_i      = 1'b0;
        valid_i    = 1'b0;
        m_if.ready = 1'b1;
        repeat (10) tick();
        check("rst_seq_stale", 32'(got_q.size()), 32'h0);
        drive(1'b1, 32'(7) << 15, DW'(1), 1'b0);
        valid_i = 1'b0;
        repeat (6) tick();
        exp_q = '{16'd7};
        compare_queues("post_rst");

        // Randomized run against the reference model
        do_reset();
        prev_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            v = 1'($urandom_range(0, 1));
            d = $urandom;
            if ($urandom_range(0, 1) == 1) d = 32'($signed(d) >>> 10);
            if ($urandom_range(0, 3) == 0) d[14:0] = 15'h4000;
            dec  = DW'($urandom_range(2, 5));
            mode = 1'($urandom_range(0, 1));
            rdy  = prev_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            prev_ready = rdy;
            m_if.ready = rdy;
            model_step(v, d, dec, mode);
            drive(v, d, dec, mode);
        end
        valid_i    = 1'b0;
        m_if.ready = 1'b1;
        repeat (20) tick();
        compare_queues("random");
        check("random_ovf", {31'h0, ovf_o}, 32'h0);
        check("random_sat", {31'h0, sat_o}, {31'h0, mdl_sat});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
